// File: rtl/z_run_monitor_pkg.sv
// ---------------------------------------------------------------------------
// z_run_monitor_pkg
// Shared definitions for the z run monitor: run-tracking FSM state encoding
// and the default widths / minimum qualifying run length.
// ---------------------------------------------------------------------------
package z_run_monitor_pkg;

    // Run-tracking FSM states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

    // Default parameter values
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_MIN_RUN = 2;

endpackage : z_run_monitor_pkg

// File: rtl/z_run_monitor_if.sv
// ---------------------------------------------------------------------------
// z_run_monitor_if
// Bundles the detector input, the software clear, and the event
// valid/ack reporting signals of the z run monitor.
//   master : drives z, clear, evt_ack; observes the event/status outputs
//   slave  : the monitor itself (consumes z/clear/evt_ack, drives outputs)
// Signals:
//   z          detector output, sampled every rising edge
//   clear      synchronous clear of evt_count and overflow
//   evt_ack    consumer accepts the pending event
//   evt_valid  event pending, held until acked
//   evt_len    length of the pending run (LEN_W bits)
//   evt_count  qualified events since reset/clear (CNT_W bits, saturating)
//   overflow   sticky: an event was lost
// ---------------------------------------------------------------------------
interface z_run_monitor_if #(
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) ();
    logic             z;
    logic             clear;
    logic             evt_ack;
    logic             evt_valid;
    logic [LEN_W-1:0] evt_len;
    logic [CNT_W-1:0] evt_count;
    logic             overflow;

    modport master (
        output z, clear, evt_ack,
        input  evt_valid, evt_len, evt_count, overflow
    );

    modport slave (
        input  z, clear, evt_ack,
        output evt_valid, evt_len, evt_count, overflow
    );
endinterface : z_run_monitor_if

// File: rtl/z_run_monitor_sat_counter.sv
// ---------------------------------------------------------------------------
// z_run_monitor_sat_counter
// W-bit saturating up-counter with asynchronous active-high reset.
// clr has priority over inc; once all ones the counter holds.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset (q -> 0)
//   inc    count up by one (unless saturated)
//   clr    synchronous clear to 0
//   q      current count
// ---------------------------------------------------------------------------
module z_run_monitor_sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule : z_run_monitor_sat_counter

// File: rtl/z_run_monitor.sv
// ---------------------------------------------------------------------------
// z_run_monitor
// Measures runs of consecutive z=1 cycles. A run that ends with at least
// MIN_RUN cycles is a qualified event: its (saturated) length is presented
// on evt_len with evt_valid held until evt_ack. A qualified end while an
// un-acked event is pending is lost (oldest kept) and sets sticky overflow.
// evt_count counts every qualified end, saturating.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    z_run_monitor_if.slave (z, clear, evt_ack in;
//          evt_valid, evt_len, evt_count, overflow out)
// ---------------------------------------------------------------------------
module z_run_monitor
    import z_run_monitor_pkg::*;
#(
    parameter int LEN_W   = DEF_LEN_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int MIN_RUN = DEF_MIN_RUN
) (
    input  logic           clk,
    input  logic           reset,
    z_run_monitor_if.slave bus
);

    run_state_e       state_q, state_d;
    logic             evt_valid_q, evt_valid_d;
    logic [LEN_W-1:0] evt_len_q, evt_len_d;
    logic             overflow_q, overflow_d;

    logic [LEN_W-1:0] run_len;
    logic [CNT_W-1:0] evt_count;
    logic             run_end;
    logic             qual_end;

    // A run ends on the edge where we are in RUN and z has dropped.
    assign run_end  = (state_q == ST_RUN) && !bus.z;
    assign qual_end = run_end && (run_len >= LEN_W'(MIN_RUN));

    // run_len: entering RUN from IDLE counts from 0 to 1, so inc=z covers
    // both the first cycle and the continuation; cleared as the run ends.
    z_run_monitor_sat_counter #(.W(LEN_W)) u_run_len (
        .clk   (clk),
        .reset (reset),
        .inc   (bus.z),
        .clr   (run_end),
        .q     (run_len)
    );

    // Counts every qualified end, including lost ones; clear wins.
    z_run_monitor_sat_counter #(.W(CNT_W)) u_evt_count (
        .clk   (clk),
        .reset (reset),
        .inc   (qual_end),
        .clr   (bus.clear),
        .q     (evt_count)
    );

    always_comb begin
        state_d     = state_q;
        evt_valid_d = evt_valid_q;
        evt_len_d   = evt_len_q;
        overflow_d  = overflow_q;

        unique case (state_q)
            ST_IDLE: if (bus.z)  state_d = ST_RUN;
            ST_RUN:  if (!bus.z) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (qual_end) begin
            if (!evt_valid_q) begin
                evt_valid_d = 1'b1;
                evt_len_d   = run_len;
            end else if (bus.evt_ack) begin
                // Old event consumed this edge; the new one takes its slot.
                evt_len_d   = run_len;
            end else begin
                // Slot still occupied: keep the oldest, flag the loss.
                overflow_d  = 1'b1;
            end
        end else if (evt_valid_q && bus.evt_ack) begin
            evt_valid_d = 1'b0;
        end

        if (bus.clear) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            evt_valid_q <= 1'b0;
            evt_len_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            evt_valid_q <= evt_valid_d;
            evt_len_q   <= evt_len_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.evt_valid = evt_valid_q;
    assign bus.evt_len   = evt_len_q;
    assign bus.evt_count = evt_count;
    assign bus.overflow  = overflow_q;

endmodule : z_run_monitor

// File: tb/tb_z_run_monitor.sv
// ---------------------------------------------------------------------------
// tb_z_run_monitor
// Self-checking bench: directed vector table, hand-written multi-cycle
// sequences (saturation, narrow widths, reset mid-run) and randomized
// stimulus against a behavioural model of runs and pending events.
// ---------------------------------------------------------------------------
module tb_z_run_monitor;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    z_run_monitor_if #(.LEN_W(4), .CNT_W(8)) bus1 ();
    z_run_monitor_if #(.LEN_W(3), .CNT_W(2)) bus2 ();

    z_run_monitor #(.LEN_W(4), .CNT_W(8), .MIN_RUN(2)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    z_run_monitor #(.LEN_W(3), .CNT_W(2), .MIN_RUN(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       z;
        logic       clear;
        logic       ack;
        logic       exp_valid;
        logic [3:0] exp_len;
        logic [7:0] exp_cnt;
        logic       exp_ov;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic z, input logic c, input logic a,
                       input logic v, input int l, input int cnt, input logic ov);
        vec_t r;
        r.z = z; r.clear = c; r.ack = a;
        r.exp_valid = v; r.exp_len = 4'(l); r.exp_cnt = 8'(cnt); r.exp_ov = ov;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic z, input logic c, input logic a);
        bus1.z = z; bus1.clear = c; bus1.evt_ack = a;
    endtask

    task automatic drive2(input logic z, input logic c, input logic a);
        bus2.z = z; bus2.clear = c; bus2.evt_ack = a;
    endtask

    task automatic chk1(input string tag, input logic v, input int l, input int cnt, input logic ov);
        chk({tag, ".valid"}, bus1.evt_valid, v);
        chk({tag, ".len"},   bus1.evt_len,   l);
        chk({tag, ".count"}, bus1.evt_count, cnt);
        chk({tag, ".ovf"},   bus1.overflow,  ov);
    endtask

    // Behavioural model state (random phase)
    int m_run, m_pv, m_pl, m_cnt, m_ov;

    initial begin
        drive1(0, 0, 0);
        drive2(0, 0, 0);
        reset = 1'b1;
        repeat (2) cyc();
        chk1("reset", 0, 0, 0, 0);
        chk("reset.dut2.valid", bus2.evt_valid, 0);
        reset = 1'b0;

        // ---- Directed table (dut1: LEN_W=4, CNT_W=8, MIN_RUN=2) ----
        // run of 1: dropped
        add(1,0,0, 0,0,0,0); add(0,0,0, 0,0,0,0); add(0,0,0, 0,0,0,0);
        // run of 3, then ack; ack with nothing pending is ignored
        add(1,0,0, 0,0,0,0); add(1,0,0, 0,0,0,0); add(1,0,0, 0,0,0,0);
        add(0,0,0, 1,3,1,0); add(0,0,1, 0,3,1,0); add(0,0,1, 0,3,1,0);
        add(0,1,0, 0,3,0,0);
        // run of 2 then run of 5 with no ack -> oldest kept, overflow
        add(1,0,0, 0,3,0,0); add(1,0,0, 0,3,0,0); add(0,0,0, 1,2,1,0);
        for (int i = 0; i < 5; i++) add(1,0,0, 1,2,1,0);
        add(0,0,0, 1,2,2,1);
        add(0,1,0, 1,2,0,0);
        // ack coinciding with a len-4 qualified end -> replace, no overflow
        for (int i = 0; i < 4; i++) add(1,0,0, 1,2,0,0);
        add(0,0,1, 1,4,1,0); add(0,0,1, 0,4,1,0);
        // clear coinciding with a qualified end: clear wins for count
        add(1,0,0, 0,4,1,0); add(1,0,0, 0,4,1,0);
        add(0,1,0, 1,2,0,0); add(0,0,1, 0,2,0,0);

        foreach (vecs[i]) begin
            drive1(vecs[i].z, vecs[i].clear, vecs[i].ack);
            cyc();
            $display("vec %0d: z=%0b clr=%0b ack=%0b -> valid=%0b len=%0d cnt=%0d ovf=%0b",
                     i, vecs[i].z, vecs[i].clear, vecs[i].ack,
                     bus1.evt_valid, bus1.evt_len, bus1.evt_count, bus1.overflow);
            chk1($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_len,
                 vecs[i].exp_cnt, vecs[i].exp_ov);
        end

        // ---- Saturating run on dut1: 20 cycles of z -> len 15 ----
        for (int i = 0; i < 20; i++) begin drive1(1,0,0); cyc(); end
        drive1(0,0,0); cyc();
        $display("sat run: valid=%0b len=%0d cnt=%0d", bus1.evt_valid, bus1.evt_len, bus1.evt_count);
        chk1("sat16", 1, 15, 1, 0);
        drive1(0,0,1); cyc(); drive1(0,0,0);
        chk("sat16.ack", bus1.evt_valid, 0);

        // ---- dut2 (LEN_W=3, CNT_W=2): len saturates at 7, count at 3 ----
        for (int i = 0; i < 10; i++) begin drive2(1,0,0); cyc(); end
        drive2(0,0,0); cyc();
        $display("dut2 run10: valid=%0b len=%0d cnt=%0d", bus2.evt_valid, bus2.evt_len, bus2.evt_count);
        chk("dut2.len7", bus2.evt_len, 7);
        chk("dut2.valid", bus2.evt_valid, 1);
        drive2(0,0,1); cyc();
        for (int k = 0; k < 4; k++) begin
            drive2(1,0,0); cyc(); cyc();
            drive2(0,0,0); cyc();
            drive2(0,0,1); cyc();
        end
        drive2(0,0,0);
        $display("dut2 5 events: cnt=%0d len=%0d", bus2.evt_count, bus2.evt_len);
        chk("dut2.cnt_sat", bus2.evt_count, 3);
        chk("dut2.len2", bus2.evt_len, 2);

        // ---- Reset mid-run: run discarded, everything zero ----
        drive1(0,1,0); cyc(); drive1(0,0,0);
        for (int i = 0; i < 3; i++) begin drive1(1,0,0); cyc(); end
        reset = 1'b1;
        #2;
        chk1("rst_async", 0, 0, 0, 0);
        cyc();
        reset = 1'b0;
        drive1(0,0,0);
        for (int i = 0; i < 3; i++) cyc();
        $display("reset mid-run: valid=%0b len=%0d cnt=%0d ovf=%0b",
                 bus1.evt_valid, bus1.evt_len, bus1.evt_count, bus1.overflow);
        chk1("rst_midrun", 0, 0, 0, 0);

        // ---- Randomized run against the behavioural model ----
        m_run = 0; m_pv = 0; m_pl = 0; m_cnt = 0; m_ov = 0;
        for (int i = 0; i < 3000; i++) begin
            logic rz, rc, ra;
            int   len;
            bit   qual, lost;
            if ($urandom_range(99) < 75) rz = bus1.z; else rz = ~bus1.z;
            rc = ($urandom_range(99) < 3);
            ra = ($urandom_range(99) < 30);
            drive1(rz, rc, ra);

            qual = 0; lost = 0; len = 0;
            if (rz) begin
                m_run++;
            end else begin
                if (m_run > 0) begin
                    len  = (m_run > 15) ? 15 : m_run;
                    qual = (len >= 2);
                end
                m_run = 0;
            end
            if (qual) begin
                if (m_pv == 0) begin m_pv = 1; m_pl = len; end
                else if (ra) m_pl = len;
                else lost = 1;
            end else if (m_pv != 0 && ra) begin
                m_pv = 0;
            end
            if (rc) begin
                m_cnt = 0; m_ov = 0;
            end else begin
                if (qual) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
                if (lost) m_ov = 1;
            end

            cyc();
            if (qual)
                $display("rand %0d: run len=%0d lost=%0b -> valid=%0b len=%0d cnt=%0d ovf=%0b",
                         i, len, lost, bus1.evt_valid, bus1.evt_len, bus1.evt_count, bus1.overflow);
            chk1($sformatf("rand%0d", i), m_pv[0], m_pl, m_cnt, m_ov[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_z_run_monitor
